// File: rtl/accum_counter_param.sv
// Parametrised up/down accumulator with wrap or saturate at MAX_VAL.
// Also provides a one-cycle boundary pulse and a sticky overflow flag.
module accum_counter_param #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int STEP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              w_en,
    input  logic              up_dn,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    input  logic              ovf_clr,
    output logic [WIDTH-1:0]  dout,
    output logic              bnd,
    output logic              ovf,
    output logic              at_max,
    output logic              at_zero
);

    // A step no larger than MAX_VAL means one correction always brings a result back in range.
    if (STEP_W > WIDTH || MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1 || MAX_VAL < 2**STEP_W - 1) begin : g_bad_params
        $error("accum_counter_param: illegal WIDTH/MAX_VAL/STEP_W combination");
    end

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   LIMIT   = (WIDTH+1)'(MAX_VAL + 1);

    logic [WIDTH:0]   dout_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] count_next;
    logic             count_bnd;
    logic [WIDTH-1:0] load_clamped;

    assign dout_ext     = {1'b0, dout};
    assign step_ext     = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign sum          = dout_ext + step_ext;
    assign load_clamped = ({1'b0, load_val} > MAX_EXT) ? MAX_W : load_val;

    always_comb begin
        count_next = dout;
        count_bnd  = 1'b0;
        if (up_dn) begin
            if (sum <= MAX_EXT) begin
                count_next = WIDTH'(sum);
            end else begin
                count_bnd  = 1'b1;
                count_next = sat_mode ? MAX_W : WIDTH'(sum - LIMIT);
            end
        end else begin
            if (dout_ext >= step_ext) begin
                count_next = WIDTH'(dout_ext - step_ext);
            end else begin
                count_bnd  = 1'b1;
                count_next = sat_mode ? '0 : WIDTH'(dout_ext + LIMIT - step_ext);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
            bnd  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (clr) begin
                dout <= '0;
                bnd  <= 1'b0;
            end else if (load) begin
                dout <= load_clamped;
                bnd  <= 1'b0;
            end else if (w_en) begin
                dout <= count_next;
                bnd  <= count_bnd;
            end else begin
                bnd  <= 1'b0;
            end
            // A boundary event on the same edge as ovf_clr keeps the flag set.
            if (!clr && !load && w_en && count_bnd) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign at_max  = (dout == MAX_W);
    assign at_zero = (dout == '0);

endmodule

// File: tb/tb_accum_counter_param.sv
// Directed bench for accum_counter_param: default 8-bit instance and a MAX_VAL=99 instance
// share all inputs; each scenario checks the instance it targets.
module tb_accum_counter_param;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst;
    logic       clr, load, w_en, up_dn, sat_mode, ovf_clr;
    logic [7:0] load_val;
    logic [3:0] step;

    logic [7:0] d_dout, h_dout;
    logic       d_bnd, d_ovf, d_at_max, d_at_zero;
    logic       h_bnd, h_ovf, h_at_max, h_at_zero;

    int tests_run = 0;
    int tests_failed = 0;

    accum_counter_param u_def (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .w_en(w_en), .up_dn(up_dn), .step(step), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
        .dout(d_dout), .bnd(d_bnd), .ovf(d_ovf), .at_max(d_at_max), .at_zero(d_at_zero)
    );

    accum_counter_param #(.WIDTH(8), .MAX_VAL(99), .STEP_W(4)) u_99 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .w_en(w_en), .up_dn(up_dn), .step(step), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
        .dout(h_dout), .bnd(h_bnd), .ovf(h_ovf), .at_max(h_at_max), .at_zero(h_at_zero)
    );

    // Clock can be frozen (held at its current level) to show reset acting without edges.
    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle();
        clr = 0; load = 0; load_val = 8'h00; w_en = 0; up_dn = 1;
        step = 4'd0; sat_mode = 0; ovf_clr = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        idle();
        load = 1; load_val = v;
        cycle();
        load = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        tests_run++;
        if (d_dout !== 8'h00 || d_bnd !== 1'b0 || d_ovf !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_initial: got dout=%0h bnd=%0b ovf=%0b expected 0/0/0", d_dout, d_bnd, d_ovf);
        end
        rst = 1'b1;
        do_load(8'hFF);
        w_en = 1; step = 4'd1; up_dn = 1;
        cycle();
        do_load(8'h37);
        tests_run++;
        if (d_dout !== 8'h37 || d_ovf !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_setup: got dout=%0h ovf=%0b expected 37/1", d_dout, d_ovf);
        end
        w_en = 1; step = 4'd1; up_dn = 1;
        clk_run = 1'b0;
        #2 rst = 1'b0;
        #2;
        tests_run++;
        if (d_dout !== 8'h00 || d_bnd !== 1'b0 || d_ovf !== 1'b0 || h_dout !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_async: got dout=%0h bnd=%0b ovf=%0b h_dout=%0h expected 0/0/0/0",
                     d_dout, d_bnd, d_ovf, h_dout);
        end
        rst = 1'b1;
        #2 clk_run = 1'b1;
        cycle();
        tests_run++;
        if (d_dout !== 8'h01 || d_bnd !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_count: got dout=%0h bnd=%0b expected 01/0", d_dout, d_bnd);
        end
    endtask

    task automatic test_wrap_up();
        idle();
        load = 1; load_val = 8'hFE; ovf_clr = 1;
        cycle();
        idle();
        tests_run++;
        if (d_dout !== 8'hFE || d_ovf !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_up_load: got dout=%0h ovf=%0b expected fe/0", d_dout, d_ovf);
        end
        w_en = 1; step = 4'd3; up_dn = 1; sat_mode = 0;
        cycle();
        tests_run++;
        if (d_dout !== 8'h01 || d_bnd !== 1'b1 || d_ovf !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_up_cross: got dout=%0h bnd=%0b ovf=%0b expected 01/1/1", d_dout, d_bnd, d_ovf);
        end
        cycle();
        tests_run++;
        if (d_dout !== 8'h04 || d_bnd !== 1'b0 || d_ovf !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_up_next: got dout=%0h bnd=%0b ovf=%0b expected 04/0/1", d_dout, d_bnd, d_ovf);
        end
    endtask

    task automatic test_sat_down();
        do_load(8'd5);
        w_en = 1; step = 4'd7; up_dn = 0; sat_mode = 1;
        cycle();
        tests_run++;
        if (h_dout !== 8'd0 || h_bnd !== 1'b1 || h_ovf !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sat_down_first: got dout=%0d bnd=%0b ovf=%0b expected 0/1/1", h_dout, h_bnd, h_ovf);
        end
        cycle();
        tests_run++;
        if (h_dout !== 8'd0 || h_bnd !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sat_down_repeat: got dout=%0d bnd=%0b expected 0/1", h_dout, h_bnd);
        end
        w_en = 0;
        cycle();
        tests_run++;
        if (h_dout !== 8'd0 || h_bnd !== 1'b0 || h_at_zero !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sat_down_idle: got dout=%0d bnd=%0b at_zero=%0b expected 0/0/1", h_dout, h_bnd, h_at_zero);
        end
    endtask

    task automatic test_sat_up();
        do_load(8'hFD);
        w_en = 1; step = 4'd5; up_dn = 1; sat_mode = 1;
        cycle();
        tests_run++;
        if (d_dout !== 8'hFF || d_bnd !== 1'b1 || d_at_max !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sat_up: got dout=%0h bnd=%0b at_max=%0b expected ff/1/1", d_dout, d_bnd, d_at_max);
        end
    endtask

    task automatic test_wrap_down();
        do_load(8'd2);
        w_en = 1; step = 4'd5; up_dn = 0; sat_mode = 0;
        cycle();
        tests_run++;
        if (h_dout !== 8'd97 || h_at_max !== 1'b0 || h_bnd !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_down: got dout=%0d at_max=%0b bnd=%0b expected 97/0/1", h_dout, h_at_max, h_bnd);
        end
        do_load(8'd150);
        tests_run++;
        if (h_dout !== 8'd99 || h_at_max !== 1'b1 || h_bnd !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_clamp: got dout=%0d at_max=%0b bnd=%0b expected 99/1/0", h_dout, h_at_max, h_bnd);
        end
        tests_run++;
        if (d_dout !== 8'd150 || d_at_max !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_noclamp: got dout=%0d at_max=%0b expected 150/0", d_dout, d_at_max);
        end
    endtask

    task automatic test_priority();
        do_load(8'h20);
        clr = 1; load = 1; load_val = 8'h10; w_en = 1; step = 4'd1; up_dn = 1;
        cycle();
        tests_run++;
        if (d_dout !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL prio_clr: got dout=%0h expected 00", d_dout);
        end
        clr = 0;
        cycle();
        tests_run++;
        if (d_dout !== 8'h10) begin
            tests_failed++;
            $display("[TB] FAIL prio_load: got dout=%0h expected 10", d_dout);
        end
        idle();
        ovf_clr = 1;
        cycle();
        tests_run++;
        if (d_ovf !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_clear_pre: got ovf=%0b expected 0", d_ovf);
        end
        do_load(8'hFF);
        w_en = 1; step = 4'd1; up_dn = 1; sat_mode = 0; ovf_clr = 1;
        cycle();
        tests_run++;
        if (d_dout !== 8'h00 || d_bnd !== 1'b1 || d_ovf !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ovf_set_wins: got dout=%0h bnd=%0b ovf=%0b expected 00/1/1", d_dout, d_bnd, d_ovf);
        end
        idle();
        load_val = 8'h33; clr = 1;
        cycle();
        tests_run++;
        if (d_dout !== 8'h00 || d_ovf !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL clr_keeps_ovf: got dout=%0h ovf=%0b expected 00/1", d_dout, d_ovf);
        end
        idle();
        ovf_clr = 1;
        cycle();
        tests_run++;
        if (d_ovf !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_clr_alone: got ovf=%0b expected 0", d_ovf);
        end
    endtask

    task automatic test_hold();
        logic [7:0] exp_seq [4];
        logic       dir_seq [4];
        exp_seq = '{8'h44, 8'h42, 8'h40, 8'h42};
        dir_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_load(8'h42);
        w_en = 1; step = 4'd0; up_dn = 1;
        for (int i = 0; i < 4; i++) begin
            up_dn = i[0];
            cycle();
            tests_run++;
            if (d_dout !== 8'h42 || d_bnd !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL hold_step0[%0d]: got dout=%0h bnd=%0b expected 42/0", i, d_dout, d_bnd);
            end
        end
        step = 4'd2;
        for (int i = 0; i < 4; i++) begin
            up_dn = dir_seq[i];
            cycle();
            tests_run++;
            if (d_dout !== exp_seq[i]) begin
                tests_failed++;
                $display("[TB] FAIL dir_toggle[%0d]: got dout=%0h expected %0h", i, d_dout, exp_seq[i]);
            end
        end
        w_en = 0; up_dn = 1; step = 4'd9;
        cycle();
        tests_run++;
        if (d_dout !== 8'h42 || d_bnd !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hold_disabled: got dout=%0h bnd=%0b expected 42/0", d_dout, d_bnd);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_sat_up();
        test_wrap_down();
        test_priority();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
